// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, DMA config register offsets, master FSM state.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Contents:
//   RESP_*       AXI BRESP/RRESP encodings
//   CTRL..HEAD_H byte offsets of the DMA configuration slave registers
//   mst_state_e  state encoding of the AXI4-Lite master FSM
//   resp_is_err  true for any response other than OKAY
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [7:0] CTRL   = 8'h00;
  localparam logic [7:0] STATUS = 8'h04;
  localparam logic [7:0] HEAD_L = 8'h08;
  localparam logic [7:0] HEAD_H = 8'h0C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_RSP
  } mst_state_e;

  // EXOKAY is counted as an error too: anything but plain OKAY is unexpected
  // from a non-exclusive AXI4-Lite access.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: request/response command port -> AW+W->B or AR->R.
// Latency: 3 cycles accept-to-rsp_valid with a ready slave; all outputs registered.
// Backpressure: req_ready low from accept until rsp_ready consumes the held response.
//
// Ports:
//   aclk, areset                  clock, synchronous active-high reset
//   req_valid/ready/write/addr/wdata/wstrb   command port (sampled only in IDLE)
//   rsp_valid/ready/write/rdata/resp         response port (held until rsp_ready)
//   err_count                     saturating count of non-OKAY responses
//   aw*/w*/b*/ar*/r*              AXI4-Lite initiator channels
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ERRCNT_W = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ERRCNT_W-1:0]   err_count,
  output logic [ADDR_W-1:0]     awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_W-1:0]     araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam int STRB_W = DATA_W / 8;

  mst_state_e          state_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic                rsp_write_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [1:0]          rsp_resp_q;
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;
  logic [ADDR_W-1:0]   awaddr_q, araddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                aw_done_q, w_done_q, aw_done_d, w_done_d;

  logic [ADDR_W-1:0]   bus_addr;
  logic                b_fire, r_fire;
  logic [1:0]          cap_resp;
  logic                unused_addr_lsb;

  // Word-aligned bus address; the byte offset bits are deliberately dropped.
  assign bus_addr        = {req_addr[ADDR_W-1:2], 2'b00};
  assign unused_addr_lsb = ^req_addr[1:0];

  // AW and W complete independently; a channel counts as done from the cycle
  // its own handshake happens, so both may finish in the same cycle.
  assign aw_done_d = aw_done_q | (awvalid_q & awready);
  assign w_done_d  = w_done_q  | (wvalid_q  & wready);

  // bready/rready are only ever high in their response states, so an early
  // bvalid/rvalid from the slave simply waits here.
  assign b_fire   = (state_q == ST_WR_RESP) && bvalid && bready_q;
  assign r_fire   = (state_q == ST_RD_RESP) && rvalid && rready_q;
  assign cap_resp = b_fire ? bresp : rresp;

  // Count on the response capture, i.e. on the cycle RSP is entered; hold at all-ones.
  always_comb begin
    err_count_d = err_count_q;
    if ((b_fire || r_fire) && resp_is_err(cap_resp) && !(&err_count_q)) begin
      err_count_d = err_count_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      err_count_q <= '0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      err_count_q <= err_count_d;
      case (state_q)
        ST_IDLE: begin
          // req_ready is high throughout IDLE, so req_valid alone is an accept.
          if (req_valid) begin
            req_ready_q <= 1'b0;
            rsp_write_q <= req_write;
            if (req_write) begin
              awaddr_q  <= bus_addr;
              wdata_q   <= req_wdata;
              wstrb_q   <= req_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= ST_WR_REQ;
            end else begin
              araddr_q  <= bus_addr;
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (awvalid_q && awready) awvalid_q <= 1'b0;
          if (wvalid_q && wready)   wvalid_q  <= 1'b0;
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (b_fire) begin
            bready_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= bresp;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end
        end
        ST_RD_REQ: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (r_fire) begin
            rready_q    <= 1'b0;
            rsp_rdata_q <= rdata;
            rsp_resp_q  <= rresp;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RSP;
          end
        end
        ST_RSP: begin
          // req_ready returns one cycle after the response is consumed, never
          // in the same cycle.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign err_count = err_count_q;
  assign awaddr    = awaddr_q;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign araddr    = araddr_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: directed scenarios then randomized transactions.
// Slave behaviour and expected responses come from a per-transaction plan.
// err_count width is reduced so saturation is reached within the run.
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  localparam int ERRW   = 4;
  localparam int ERRMAX = (1 << ERRW) - 1;

  logic        aclk = 1'b0;
  logic        areset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [ERRW-1:0] err_count;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axi_lite_master #(.ADDR_W(32), .DATA_W(32), .ERRCNT_W(ERRW)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  // One full transaction. d1 = AW (or AR) ready delay, d2 = W ready delay for
  // writes / R valid delay for reads, d3 = B valid delay, early_b = slave
  // raises bvalid before the write handshakes, rsp_d = cycles rsp_ready held low.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input logic [1:0] resp, input logic [31:0] rd,
                        input int d1, input int d2, input int d3, input bit early_b,
                        input int rsp_d);
    logic [31:0] ea;
    bit aw_ok, w_ok, ar_ok;
    int aw_l, w_l, ar_l;
    ea = {addr[31:2], 2'b00};
    aw_ok = 0; w_ok = 0; ar_ok = 0;
    aw_l = d1; w_l = d2; ar_l = d1;

    chk("req_ready_idle", 64'(req_ready), 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = strb;
    step();
    // Scramble the command inputs: the DUT must be working from its latched copy.
    req_valid = 1'b0; req_write = ~wr; req_addr = $urandom; req_wdata = $urandom;
    req_wstrb = 4'($urandom);
    chk("req_ready_busy", 64'(req_ready), 0);

    if (wr) begin
      if (early_b) begin bvalid = 1'b1; bresp = resp; end
      while (!(aw_ok && w_ok)) begin
        if (!aw_ok) begin
          chk("awvalid_hold", 64'(awvalid), 1);
          chk("awaddr", 64'(awaddr), 64'(ea));
        end else chk("awvalid_drop", 64'(awvalid), 0);
        if (!w_ok) begin
          chk("wvalid_hold", 64'(wvalid), 1);
          chk("wdata", 64'(wdata), 64'(wd));
          chk("wstrb", 64'(wstrb), 64'(strb));
        end else chk("wvalid_drop", 64'(wvalid), 0);
        chk("bready_early", 64'(bready), 0);
        chk("rsp_valid_early", 64'(rsp_valid), 0);
        chk("arvalid_on_write", 64'(arvalid), 0);
        awready = !aw_ok && (aw_l == 0);
        wready  = !w_ok && (w_l == 0);
        @(posedge aclk);
        if (awready) aw_ok = 1; else if (!aw_ok) aw_l--;
        if (wready)  w_ok  = 1; else if (!w_ok)  w_l--;
        @(negedge aclk);
        awready = 1'b0; wready = 1'b0;
      end
      chk("awvalid_done", 64'(awvalid), 0);
      chk("wvalid_done", 64'(wvalid), 0);
      chk("bready_up", 64'(bready), 1);
      for (int i = 0; i < d3; i++) begin
        chk("rsp_valid_bwait", 64'(rsp_valid), 0);
        step();
        chk("bready_wait", 64'(bready), 1);
      end
      bvalid = 1'b1; bresp = resp;
      step();
      bvalid = 1'b0; bresp = 2'($urandom);
      chk("bready_drop", 64'(bready), 0);
    end else begin
      while (!ar_ok) begin
        chk("arvalid_hold", 64'(arvalid), 1);
        chk("araddr", 64'(araddr), 64'(ea));
        chk("rready_early", 64'(rready), 0);
        chk("awvalid_on_read", 64'(awvalid), 0);
        arready = (ar_l == 0);
        @(posedge aclk);
        if (arready) ar_ok = 1; else ar_l--;
        @(negedge aclk);
        arready = 1'b0;
      end
      chk("arvalid_done", 64'(arvalid), 0);
      chk("rready_up", 64'(rready), 1);
      for (int i = 0; i < d2; i++) begin
        chk("rsp_valid_rwait", 64'(rsp_valid), 0);
        step();
        chk("rready_wait", 64'(rready), 1);
      end
      rvalid = 1'b1; rdata = rd; rresp = resp;
      step();
      rvalid = 1'b0; rdata = $urandom; rresp = 2'($urandom);
      chk("rready_drop", 64'(rready), 0);
    end

    if (resp != RESP_OKAY && exp_err < ERRMAX) exp_err++;
    chk("rsp_valid", 64'(rsp_valid), 1);
    chk("rsp_write", 64'(rsp_write), 64'(wr));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(wr ? 32'h0 : rd));
    chk("rsp_resp", 64'(rsp_resp), 64'(resp));
    chk("err_count", 64'(err_count), 64'(exp_err));

    // Hold the response and offer a new command that must be ignored.
    for (int i = 0; i < rsp_d; i++) begin
      req_valid = 1'b1; req_write = 1'($urandom); req_addr = $urandom;
      step();
      chk("hold_rsp_valid", 64'(rsp_valid), 1);
      chk("hold_rsp_write", 64'(rsp_write), 64'(wr));
      chk("hold_rsp_rdata", 64'(rsp_rdata), 64'(wr ? 32'h0 : rd));
      chk("hold_rsp_resp", 64'(rsp_resp), 64'(resp));
      chk("hold_req_ready", 64'(req_ready), 0);
      chk("hold_no_axi", 64'({awvalid, wvalid, arvalid}), 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_clear", 64'(rsp_valid), 0);
    chk("req_ready_back", 64'(req_ready), 1);
    chk("err_count_after", 64'(err_count), 64'(exp_err));
  endtask

  initial begin
    logic [1:0]  r_resp;
    logic [31:0] r_addr;
    int          r_d3;
    bit          r_eb;

    areset = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);

    // Reset state
    chk("rst_req_ready", 64'(req_ready), 1);
    chk("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 0);
    chk("rst_rsp", 64'({rsp_write, rsp_resp, rsp_rdata}), 0);
    chk("rst_err_count", 64'(err_count), 0);
    chk("rst_addrs", 64'({awaddr, araddr}), 0);
    chk("rst_wdata", 64'({wdata, wstrb}), 0);
    areset = 1'b0;
    step();

    // Ready slave, OKAY write to CTRL
    do_txn(1'b1, 32'(CTRL), 32'h0000_0001, 4'hF, RESP_OKAY, 32'h0, 0, 0, 0, 1'b0, 0);
    // W handshakes two cycles before AW, B three cycles after
    do_txn(1'b1, 32'(HEAD_L), 32'h8000_1000, 4'hF, RESP_OKAY, 32'h0, 2, 0, 3, 1'b0, 0);
    // Read STATUS with a four-cycle arready delay
    do_txn(1'b0, 32'(STATUS), 32'h0, 4'h0, RESP_OKAY, 32'h0000_0001, 4, 0, 0, 1'b0, 0);
    // Error responses
    do_txn(1'b1, 32'(HEAD_H), 32'hDEAD_BEEF, 4'h3, RESP_SLVERR, 32'h0, 1, 1, 0, 1'b0, 0);
    do_txn(1'b0, 32'(CTRL), 32'h0, 4'h0, RESP_DECERR, 32'h1234_5678, 0, 2, 0, 1'b0, 0);
    chk("err_count_two", 64'(err_count), 2);
    // Response held for five cycles; early bvalid
    do_txn(1'b1, 32'(CTRL), 32'h0000_00A5, 4'h1, RESP_OKAY, 32'h0, 0, 1, 0, 1'b1, 5);

    // Reset while AW/W are pending and never accepted
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_000E;
    req_wdata = 32'h5555_AAAA; req_wstrb = 4'hF;
    step();
    req_valid = 1'b0;
    chk("rst_mid_awaddr", 64'(awaddr), 64'(32'h0000_000C));
    chk("rst_mid_awvalid", 64'(awvalid), 1);
    repeat (3) step();
    chk("rst_mid_awvalid_held", 64'(awvalid), 1);
    areset = 1'b1;
    step();
    areset = 1'b0;
    exp_err = 0;
    chk("rst_mid_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 0);
    chk("rst_mid_req_ready", 64'(req_ready), 1);
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_mid_err_count", 64'(err_count), 0);
    step();
    chk("rst_mid_no_rsp", 64'(rsp_valid), 0);

    // Randomized traffic; error rate high enough to saturate err_count
    for (int t = 0; t < 200; t++) begin
      r_resp = ($urandom_range(0, 1) == 0) ? RESP_OKAY : 2'($urandom);
      r_addr = ($urandom_range(0, 3) == 0) ? $urandom
             : 32'($urandom_range(0, 3) * 4 + $urandom_range(0, 3));
      r_eb   = ($urandom_range(0, 3) == 0);
      r_d3   = r_eb ? 0 : $urandom_range(0, 3);
      do_txn(1'($urandom), r_addr, $urandom, 4'($urandom), r_resp, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), r_d3, r_eb, $urandom_range(0, 2));
    end
    chk("err_count_saturated", 64'(err_count), 64'(exp_err));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
